mips_debug_loader: RTL and testbench

Parametrised program loader and run controller for the pipelined MIPS core. It takes a byte stream from the UART receive FIFO and assembles it into instruction words. Those words are written into program memory, and the core is then gated in single-step or continuous mode until it reports completion. It sits between the UART/FIFO front end and the MIPS core's enable and program-memory write ports.

---
 rtl/mips_dbg_pkg.sv | 27 ++
 rtl/mips_debug_loader_byte_packer.sv | 40 ++++
 rtl/mips_debug_loader.sv | 146 ++++++++++++++
 tb/tb_mips_debug_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and sizing helpers for the MIPS debug program loader.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } ld_state_t;

  // Bytes per instruction word for the default 32-bit core.
  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned byte_cnt_w(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  // Width wide enough to hold both an 8-bit header and DEPTH = 2**addr_w.
  function automatic int unsigned hdr_cmp_w(input int unsigned addr_w);
    return (addr_w + 1 > 8) ? addr_w + 1 : 8;
  endfunction

endpackage

// File: rtl/mips_debug_loader_byte_packer.sv
// MSB-first byte-to-word packer; word_valid flags the byte that completes a word.
module byte_packer
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        byte_in,
  input  logic              byte_en,
  input  logic              clear,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid
);

  localparam int unsigned BPW = bytes_per_word(DATA_W);
  localparam int unsigned CW  = byte_cnt_w(BPW);

  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     cnt;
  logic              last;

  assign last       = (cnt == CW'(BPW - 1));
  assign word_out   = (shift << 8) | DATA_W'(byte_in);
  assign word_valid = byte_en && last;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shift <= word_out;
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips_debug_loader.sv
// Program loader / run controller for the pipelined MIPS core.
// Optional inter-byte timeout in LOAD is enabled by defining LOADER_TIMEOUT_EN.
module mips_debug_loader
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              run_cont,
  input  logic              step_req,
  input  logic              cpu_finished,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned HDR_W = hdr_cmp_w(ADDR_W);

  if ((DATA_W % 8) != 0 || DATA_W == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("mips_debug_loader: DATA_W must be a non-zero multiple of 8 and TIMEOUT_CYC >= 1");
  end

  ld_state_t state, state_n;

  logic              accept, hdr_seen, hdr_zero, hdr_big;
  logic              load_done, timeout, byte_en, pack_clear;
  logic              word_valid, step_edge;
  logic [HDR_W-1:0]  hdr_ext;
  logic [CNT_W-1:0]  word_cnt, word_total;
  logic [DATA_W-1:0] word_out;
  logic [2:0]        step_sync;

  assign rx_ready  = (state != ST_RUN);
  assign accept    = rx_valid && rx_ready;
  assign hdr_ext   = HDR_W'(rx_data);
  assign hdr_zero  = (rx_data == '0);
  assign hdr_big   = (hdr_ext > HDR_W'(DEPTH));
  assign hdr_seen  = accept && (state == ST_IDLE || state == ST_DONE);
  // Final write is still on the bus; RUN begins on the edge that retires it.
  assign load_done = (state == ST_LOAD) && pm_we && (word_cnt == word_total);
  assign byte_en   = (state == ST_LOAD) && accept && (word_cnt != word_total);
  assign step_edge = step_sync[1] && !step_sync[2];
  assign pack_clear = (state != ST_LOAD) || timeout;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] to_cnt;

  assign timeout = (state == ST_LOAD) && !accept && !load_done &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                         to_cnt <= '0;
    else if (state != ST_LOAD || accept || timeout)    to_cnt <= '0;
    else                                               to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .CLK       (CLK),
    .RESET     (RESET),
    .byte_in   (rx_data),
    .byte_en   (byte_en),
    .clear     (pack_clear),
    .word_out  (word_out),
    .word_valid(word_valid)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      step_sync <= '0;
    end else begin
      state     <= state_n;
      step_sync <= {step_sync[1:0], step_req};
    end
  end

  always_comb begin
    state_n = state;
    cpu_en  = 1'b0;
    cpu_rst = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (hdr_seen) state_n = (hdr_zero || hdr_big) ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
        if (load_done)    state_n = ST_RUN;
        else if (timeout) state_n = ST_IDLE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cpu_finished) state_n = ST_DONE;
        else              cpu_en  = run_cont || step_edge;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      load_err   <= 1'b0;
    end else begin
      pm_we <= 1'b0;
      if (hdr_seen) begin
        load_err   <= hdr_big;
        word_cnt   <= '0;
        word_total <= CNT_W'(hdr_ext);
      end else if (timeout) begin
        load_err <= 1'b1;
      end
      if (word_valid) begin
        pm_we    <= 1'b1;
        pm_addr  <= word_cnt[ADDR_W-1:0];
        pm_wdata <= word_out;
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_debug_loader.sv
// Self-checking bench for mips_debug_loader (DATA_W=32, ADDR_W=5, TIMEOUT_CYC=16).
module tb_mips_debug_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TO     = 16;
  localparam int DEPTH  = 32;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  typedef logic [7:0] bq_t[$];

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              run_cont = 1'b0;
  logic              step_req = 1'b0;
  logic              cpu_finished = 1'b0;
  logic              rx_ready, cpu_en, cpu_rst, pm_we, busy, done, load_err;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_wdata;

  always #5 CLK = ~CLK;

  mips_debug_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .run_cont(run_cont), .step_req(step_req), .cpu_finished(cpu_finished),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .busy(busy), .done(done), .load_err(load_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, header count, words written, partial word as an integer.
  int          m_mode = M_IDLE;
  int          m_total, m_words, m_nbytes, m_stall;
  logic [31:0] m_word;
  bit          m_err, m_we, m_acc, m_we_n;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(posedge CLK) begin
    if (RESET) begin
      m_mode = M_IDLE; m_total = 0; m_words = 0; m_nbytes = 0; m_stall = 0;
      m_word = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_acc  = rx_valid && (m_mode != M_RUN);
      m_we_n = 0;
      case (m_mode)
        M_IDLE, M_DONE: if (m_acc) begin
          m_err = (rx_data > DEPTH);
          if (rx_data >= 1 && rx_data <= DEPTH) begin
            m_mode = M_LOAD; m_total = rx_data; m_words = 0;
            m_nbytes = 0; m_word = 0; m_stall = 0;
          end else m_mode = M_IDLE;
        end
        M_LOAD: begin
          if (m_we && m_words == m_total) m_mode = M_RUN;
          else if (m_acc) begin
            m_stall = 0;
            if (m_words < m_total) begin
              m_word = m_word * 256 + rx_data;
              m_nbytes++;
              if (m_nbytes == 4) begin
                m_we_n = 1; m_addr = m_words[4:0]; m_data = m_word;
                m_words++; m_nbytes = 0; m_word = 0;
              end
            end
          end else begin
`ifdef LOADER_TIMEOUT_EN
            m_stall++;
            if (m_stall == TO) begin
              m_err = 1; m_mode = M_IDLE; m_nbytes = 0; m_word = 0;
            end
`endif
          end
        end
        M_RUN: if (cpu_finished) m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
      m_we = m_we_n;
    end
  end

  // Per-cycle comparison, mid-cycle.
  always @(negedge CLK) begin
    if (RESET) begin
      chk("rst_rx_ready", rx_ready, 1'b1);
      chk("rst_cpu_en", cpu_en, 1'b0);
      chk("rst_cpu_rst", cpu_rst, 1'b0);
      chk("rst_pm_we", pm_we, 1'b0);
      chk("rst_pm_addr", pm_addr, 0);
      chk("rst_pm_wdata", pm_wdata, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_load_err", load_err, 1'b0);
    end else begin
      chk("rx_ready", rx_ready, m_mode != M_RUN);
      chk("busy", busy, m_mode == M_LOAD || m_mode == M_RUN);
      chk("done", done, m_mode == M_DONE);
      chk("cpu_rst", cpu_rst, m_mode == M_LOAD);
      chk("load_err", load_err, m_err);
      chk("pm_we", pm_we, m_we);
      if (m_we) begin
        chk("pm_addr", pm_addr, m_addr);
        chk("pm_wdata", pm_wdata, m_data);
      end
      if (m_mode != M_RUN || cpu_finished) chk("cpu_en_off", cpu_en, 1'b0);
      else if (run_cont)                  chk("cpu_en_cont", cpu_en, 1'b1);
    end
  end

  int          en_cycles = 0, en_rises = 0;
  logic        en_prev = 1'b0;
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge CLK) begin
    if (cpu_en) en_cycles++;
    if (cpu_en && !en_prev) en_rises++;
    en_prev = cpu_en;
    if (pm_we) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input bq_t b);
    foreach (b[i]) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      @(posedge CLK); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic finish_run();
    cpu_finished = 1'b1;
    tick(1);
    cpu_finished = 1'b0;
    tick(1);
  endtask

  bq_t q;
  int  n0, base_c, base_r;

  initial begin
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(2);

    // Two-word load
    q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    send(q);
    tick(3);
    chk("load2_count", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      chk("load2_addr0", wr_addr[0], 0);
      chk("load2_data0", wr_data[0], 32'h20010005);
      chk("load2_addr1", wr_addr[1], 1);
      chk("load2_data1", wr_data[1], 32'h00000000);
    end
    chk("run_cpu_rst", cpu_rst, 1'b0);
    chk("run_busy", busy, 1'b1);

    // Three step pulses
    base_c = en_cycles; base_r = en_rises;
    repeat (3) begin
      step_req = 1'b1; tick(2);
      step_req = 1'b0; tick(4);
    end
    tick(4);
    chk("step3_cycles", en_cycles - base_c, 3);
    chk("step3_rises", en_rises - base_r, 3);

    // Held step_req gives a single pulse
    base_c = en_cycles; base_r = en_rises;
    step_req = 1'b1; tick(20);
    step_req = 1'b0; tick(5);
    chk("stephold_cycles", en_cycles - base_c, 1);
    chk("stephold_rises", en_rises - base_r, 1);

    // Continuous run, finish on the 10th cycle
    run_cont = 1'b1;
    tick(9);
    cpu_finished = 1'b1;
    @(negedge CLK);
    chk("fin_cpu_en", cpu_en, 1'b0);
    @(posedge CLK); #1;
    cpu_finished = 1'b0;
    run_cont = 1'b0;
    @(negedge CLK);
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    tick(1);

    // New header from DONE
    n0 = wr_data.size();
    q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(q);
    tick(3);
    chk("reload_count", wr_data.size(), n0 + 1);
    chk("reload_addr", wr_addr[wr_addr.size()-1], 0);
    chk("reload_data", wr_data[wr_data.size()-1], 32'hDEADBEEF);
    finish_run();

    // Oversize header, then zero header
    n0 = wr_data.size();
    q = '{8'h21};
    send(q);
    tick(2);
    chk("big_err", load_err, 1'b1);
    chk("big_busy", busy, 1'b0);
    chk("big_done", done, 1'b0);
    chk("big_nowrite", wr_data.size(), n0);
    q = '{8'h00};
    send(q);
    tick(2);
    chk("zero_err", load_err, 1'b0);
    chk("zero_busy", busy, 1'b0);
    chk("zero_nowrite", wr_data.size(), n0);

    // Full-depth load, N = DEPTH
    q = '{8'h20};
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(8'(i)); q.push_back(8'(i)); q.push_back(8'(i)); q.push_back(8'(i));
    end
    send(q);
    tick(3);
    chk("full_count", wr_data.size(), n0 + DEPTH);
    chk("full_last_addr", wr_addr[wr_addr.size()-1], 31);
    chk("full_last_data", wr_data[wr_data.size()-1], 32'h1F1F1F1F);
    chk("full_busy", busy, 1'b1);
    finish_run();

    // Reset after two bytes of a word
    q = '{8'h01, 8'hAA, 8'hBB};
    send(q);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(1);
    n0 = wr_data.size();
    q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send(q);
    tick(3);
    chk("postrst_count", wr_data.size(), n0 + 1);
    chk("postrst_addr", wr_addr[wr_addr.size()-1], 0);
    chk("postrst_data", wr_data[wr_data.size()-1], 32'h11223344);
    finish_run();

`ifdef LOADER_TIMEOUT_EN
    // Stall mid-word past the timeout
    n0 = wr_data.size();
    q = '{8'h01, 8'h55, 8'h66};
    send(q);
    tick(20);
    chk("to_err", load_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_nowrite", wr_data.size(), n0);
    q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send(q);
    tick(3);
    chk("to_reload_data", wr_data[wr_data.size()-1], 32'h01020304);
    chk("to_reload_err", load_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
